// File: rtl/id_hazard_ctrl.sv
// Decode-stage issue controller: per-register pending-write scoreboard,
// RAW/saturation stall, branch hold in BR_WAIT with taken-flush and timeout recovery.
module id_hazard_ctrl #(
  parameter int NREG       = 16,
  parameter int CNT_W      = 2,
  parameter int BR_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_rs_addr,
  input  logic       id_rs_used,
  input  logic [3:0] id_rt_addr,
  input  logic       id_rt_used,
  input  logic [3:0] id_wr_addr,
  input  logic       id_regwrite,
  input  logic       id_ctrl,
  input  logic       ex_res_valid,
  input  logic       ex_taken,
  input  logic       wb_regwrite,
  input  logic [3:0] wb_addr,
  output logic       pc_en,
  output logic       pc_sel_target,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       issue,
  output logic       sb_err
);

  localparam int TMO_W = $clog2(BR_TIMEOUT + 1);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    BR_WAIT = 1'b1
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_pend [NREG];
  logic [TMO_W-1:0]  r_tmo;
  logic              r_sb_err;

  logic              w_rs_busy;
  logic              w_rt_busy;
  logic              w_wr_sat;
  logic              w_hazard;
  logic              w_tmo_hit;
  logic              w_tmo_err;
  logic              w_underflow;
  logic [NREG-1:0]   w_inc_vec;
  logic [NREG-1:0]   w_dec_vec;

  // Write-back is not bypassed: a counter only drops at the edge, matching the bank's write timing.
  assign w_rs_busy = id_rs_used  & (|r_pend[id_rs_addr]);
  assign w_rt_busy = id_rt_used  & (|r_pend[id_rt_addr]);
  assign w_wr_sat  = id_regwrite & (&r_pend[id_wr_addr]);
  assign w_hazard  = w_rs_busy | w_rt_busy | w_wr_sat;

  assign w_tmo_hit = (r_tmo == TMO_W'(BR_TIMEOUT - 1));
  assign w_tmo_err = (r_state == BR_WAIT) & ~ex_res_valid & w_tmo_hit;

  // A retire that cancels against a same-register issue is a net no-op, not an underflow.
  assign w_underflow = wb_regwrite & ~(|r_pend[wb_addr]) &
                       ~(issue & id_regwrite & (id_wr_addr == wb_addr));

  assign sb_err = r_sb_err;

  // Per-register increment/decrement strobes for this edge.
  always_comb begin
    w_inc_vec = {NREG{1'b0}};
    w_dec_vec = {NREG{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      w_inc_vec[i] = issue & id_regwrite & (id_wr_addr == 4'(i));
      w_dec_vec[i] = wb_regwrite & (wb_addr == 4'(i));
    end
  end

  // Pipeline control outputs from current state and decode/EX inputs.
  always_comb begin
    pc_en         = 1'b0;
    pc_sel_target = 1'b0;
    ifid_en       = 1'b0;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b1;
    issue         = 1'b0;
    if (!rst) begin
      idex_bubble = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          issue = id_valid & ~w_hazard;
          if (id_valid && w_hazard) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
          end else if (!id_valid) begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end else begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_bubble = 1'b0;
          end
        end
        BR_WAIT: begin
          if (ex_res_valid && ex_taken) begin
            pc_en         = 1'b1;
            pc_sel_target = 1'b1;
            ifid_flush    = 1'b1;
          end else if (!ex_res_valid && w_tmo_hit) begin
            ifid_flush = 1'b1;
          end else begin
            pc_en = 1'b0;
          end
        end
        default: begin
          issue = 1'b0;
        end
      endcase
    end
  end

  // Scoreboard counters; saturation is prevented upstream by the hazard stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_pend[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_inc_vec[i] && !w_dec_vec[i]) begin
          r_pend[i] <= r_pend[i] + CNT_W'(1);
        end else if (w_dec_vec[i] && !w_inc_vec[i] && (|r_pend[i])) begin
          r_pend[i] <= r_pend[i] - CNT_W'(1);
        end else begin
          r_pend[i] <= r_pend[i];
        end
      end
    end
  end

  // Branch-hold FSM, timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= RUN;
      r_tmo    <= {TMO_W{1'b0}};
      r_sb_err <= 1'b0;
    end else begin
      r_sb_err <= r_sb_err | w_underflow | w_tmo_err;
      case (r_state)
        RUN: begin
          if (issue && id_ctrl) begin
            r_state <= BR_WAIT;
            r_tmo   <= {TMO_W{1'b0}};
          end else begin
            r_state <= RUN;
          end
        end
        BR_WAIT: begin
          if (ex_res_valid || w_tmo_hit) begin
            r_state <= RUN;
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

endmodule
